// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared op codes, FSM states and step count for the HI/LO unit
package mips_cpu_pkg;

    localparam int MULDIV_STEPS = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2
    } muldiv_state_t;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// rtl/mips_cpu_muldiv_step.sv - one shift-add multiply or restoring-divide iteration
module mips_cpu_muldiv_step (
    input  logic        i_is_div,
    input  logic [63:0] i_acc,
    input  logic [31:0] i_b,
    output logic [63:0] o_acc
);

    logic [32:0] w_sum;
    logic [32:0] w_rem;
    logic        w_ge;
    logic [31:0] w_diff;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        w_sum  = {1'b0, i_acc[63:32]} + (i_acc[0] ? {1'b0, i_b} : 33'd0);
        w_rem  = i_acc[63:31];
        w_ge   = (w_rem >= {1'b0, i_b});
        w_diff = w_rem[31:0] - i_b;
        if (i_is_div) begin
            o_acc = w_ge ? {w_diff, i_acc[30:0], 1'b1}
                         : {w_rem[31:0], i_acc[30:0], 1'b0};
        end else begin
            o_acc = {w_sum, i_acc[31:1]};
        end
    end

endmodule

// File: rtl/mips_cpu_muldiv_ctrl.sv
// rtl/mips_cpu_muldiv_ctrl.sv - iterative MULT/DIV sequencer with HI/LO registers and hazard stall
module mips_cpu_muldiv_ctrl
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rd_hi_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done
);

    muldiv_state_t r_state, w_next_state;
    logic [5:0]    r_cnt;
    logic [63:0]   r_acc;
    logic [31:0]   r_b;
    logic          r_is_div;
    logic          r_neg_lo;
    logic          r_neg_hi;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic          r_done;

    muldiv_op_t    w_op;
    logic          w_idle;
    logic          w_accept_iter;
    logic          w_is_signed;
    logic          w_is_div;
    logic          w_div0;
    logic          w_use_mag;
    logic [31:0]   w_a_in;
    logic [31:0]   w_b_in;
    logic [63:0]   w_step_acc;
    logic [63:0]   w_prod;
    logic [31:0]   w_quot;
    logic [31:0]   w_rem;

    assign w_op          = muldiv_op_t'(op);
    assign w_idle        = (r_state == ST_IDLE);
    assign w_accept_iter = start && w_idle && !op[2];
    assign w_is_signed   = (w_op == OP_MULT) || (w_op == OP_DIV);
    assign w_is_div      = op[1];
    assign w_div0        = w_is_div && (rt_val == 32'd0);
    // Divide by zero runs unsigned on raw operands so hi ends up holding rs_val untouched.
    assign w_use_mag     = w_is_signed && !w_div0;
    assign w_a_in        = w_use_mag ? abs32(rs_val) : rs_val;
    assign w_b_in        = w_use_mag ? abs32(rt_val) : rt_val;

    mips_cpu_muldiv_step u_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_b      (r_b),
        .o_acc    (w_step_acc)
    );

    assign w_prod = r_neg_lo ? (~r_acc + 64'd1) : r_acc;
    assign w_quot = r_neg_lo ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    assign w_rem  = r_neg_hi ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept_iter) w_next_state = ST_RUN;
            ST_RUN:   if (r_cnt == 6'(MULDIV_STEPS - 1)) w_next_state = ST_FIXUP;
            ST_FIXUP: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= 6'd0;
            r_acc    <= 64'd0;
            r_b      <= 32'd0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FIXUP);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept_iter) begin
                        r_cnt    <= 6'd0;
                        r_is_div <= w_is_div;
                        r_b      <= w_b_in;
                        r_acc    <= {32'd0, w_a_in};
                        if (w_is_div) begin
                            r_neg_lo <= w_use_mag && (rs_val[31] ^ rt_val[31]);
                            r_neg_hi <= w_use_mag && rs_val[31];
                        end else begin
                            r_neg_lo <= w_use_mag && (rs_val[31] ^ rt_val[31]);
                            r_neg_hi <= 1'b0;
                        end
                    end else if (start && (w_op == OP_MTHI)) begin
                        r_hi <= rs_val;
                    end else if (start && (w_op == OP_MTLO)) begin
                        r_lo <= rs_val;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_step_acc;
                    r_cnt <= r_cnt + 6'd1;
                end
                ST_FIXUP: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign busy  = !w_idle;
    assign stall = busy && (start || rd_hi_lo);
    assign done  = r_done;

endmodule

// File: doc/mips_cpu_muldiv_ctrl.md
MIPS_CPU_MULDIV_CTRL -- requirements
Module: mips_cpu_muldiv_ctrl

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port start  in  1  issue request from decode (HI/LO-writing instruction present).
REQ-004 SHALL have port op  in  3  operation: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; codes 6-7 are no-ops.
REQ-005 SHALL have port rs_val  in  32  operand A (multiplicand or dividend; MTHI/MTLO source).
REQ-006 SHALL have port rt_val  in  32  operand B (multiplier or divisor).
REQ-007 SHALL have port rd_hi_lo  in  1  decode holds an MFHI or MFLO.
REQ-008 SHALL have port hi  out  32  HI register.
REQ-009 SHALL have port lo  out  32  LO register.
REQ-010 SHALL have port busy  out  1  iterative operation in flight.
REQ-011 SHALL have port stall  out  1  pipeline hold request.
REQ-012 SHALL have port done  out  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and FIXUP.
REQ-014 SHALL accept start only in IDLE.
REQ-015 SHALL, on an accepted MULT/MULTU/DIV/DIVU at edge E0, latch operand magnitudes and signs (signed ops) or raw operands (unsigned ops), clear a 6-bit iteration counter, and go to RUN.
REQ-016 SHALL, in RUN, perform exactly one shift-add (multiply) or restoring-subtract (divide) step per cycle, and go to FIXUP after 32 steps (edge E32).
REQ-017 SHALL, at the FIXUP edge E33, apply sign correction, write hi and lo, and return to IDLE; done SHALL be 1 for exactly the cycle after E33.
REQ-018 SHALL hold busy=1 from the cycle after E0 through the FIXUP cycle inclusive.
REQ-019 SHALL make MULT/MULTU produce {hi,lo} equal to the full 64-bit signed or unsigned product.
REQ-020 SHALL make DIV/DIVU produce lo=quotient truncated toward zero and hi=remainder, with the remainder sign following the dividend.
REQ-021 SHALL make DIV of 0x80000000 by 0xFFFFFFFF give lo=0x80000000 and hi=0.
REQ-022 SHALL, for any divide by zero (signed or unsigned), give hi=rs_val and lo=0xFFFFFFFF, with unchanged latency.
REQ-023 SHALL make MTHI/MTLO accepted in IDLE write hi/lo from rs_val at that edge, leave the other register unchanged, keep busy=0 and done=0.
REQ-024 SHALL drive stall = busy & (start | rd_hi_lo), combinationally.
REQ-025 SHALL ignore start while busy; the held instruction is re-presented and accepted once in IDLE.
REQ-026 SHALL keep hi/lo stable throughout RUN; intermediate values SHALL never be visible on hi/lo.
REQ-027 SHALL treat op codes 6-7 with start=1 as no-ops: no state change.

Reset
REQ-028 SHALL, while rst_n=0: state=IDLE, hi=0, lo=0, busy=0, done=0, stall=0, counter=0.
REQ-029 SHALL abort an operation when reset asserts mid-operation; no partial result SHALL reach hi/lo.
REQ-030 SHALL accept start on the first rising edge with rst_n=1.

Structure
REQ-031 SHALL take the muldiv_op_t enum (op codes), the FSM state enum and MULDIV_STEPS=32 from shared package mips_cpu_pkg.
REQ-032 SHALL place the one-iteration step datapath (shift-add / restoring subtract, combinational) in sub-module mips_cpu_muldiv_step; the FSM, counter and HI/LO registers stay in this block.

Verification
REQ-033 SHALL cover: MULT rs=0xFFFFFFFE, rt=3 -> at E33 hi=0xFFFFFFFF, lo=0xFFFFFFFA; done high one cycle.
REQ-034 SHALL cover: MULTU rs=0xFFFFFFFE, rt=3 -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-035 SHALL cover: DIV rs=0xFFFFFFF9, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU rs=7, rt=0 -> hi=7, lo=0xFFFFFFFF.
REQ-036 SHALL cover: MULT, then rd_hi_lo=1 from cycle 5 -> stall=1 until busy falls after E33; MFHI then reads the new hi. A second MULT presented at cycle 10 -> stalled, then accepted in IDLE.
REQ-037 SHALL cover: rst_n pulsed low at cycle 15 of DIV -> hi=lo=0, busy=0, no done pulse; then MTHI rs=0x12345678 -> hi=0x12345678 next edge, lo=0, busy=0.
